// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and frame constants.
package spi_master_pkg;

    localparam int unsigned FRAME_W     = 32;
    localparam int unsigned CLK_DIV_MIN = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SCLK_HI = 3'd2,
        SCLK_LO = 3'd3,
        GAP     = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; both stages reset to 0.
module spi_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, 32-bit MSB-first frames, all outputs registered.
// Define SPI_MASTER_MISO_SYNC_EN to pass miso through a 2-flop synchroniser (spi_sync2).
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_data,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] rx_data,
    output logic               sclk,
    output logic               mosi,
    output logic               ss_n,
    input  logic               miso
);

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT   = 6'(FRAME_W);

    state_t             state_q, state_d;
    logic [7:0]         phase_q, phase_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
    logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_W-1:0] rx_data_d;
    logic               sclk_d, mosi_d, ss_n_d, busy_d, done_d;
    logic               phase_end;
    logic               rise;
    logic               miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
    spi_sync2 u_miso_sync (
        .clock (clock),
        .reset (reset),
        .d     (miso),
        .q     (miso_s)
    );
`else
    assign miso_s = miso;
`endif

    assign phase_end = (phase_q == PHASE_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data;
        sclk_d    = sclk;
        mosi_d    = mosi;
        ss_n_d    = ss_n;
        busy_d    = busy;
        done_d    = 1'b0;
        rise      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETUP;
                    tx_sh_d   = tx_data;
                    mosi_d    = tx_data[FRAME_W-1];
                    ss_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    sclk_d    = 1'b0;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            SETUP: begin
                if (phase_end) rise = 1'b1;
                else           phase_d = phase_q + 8'd1;
            end
            SCLK_HI: begin
                if (phase_end) begin
                    state_d = SCLK_LO;
                    sclk_d  = 1'b0;
                    phase_d = '0;
                    // After the final bit mosi simply holds; there is no next bit to present.
                    if (bit_cnt_q != LAST_BIT) begin
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[FRAME_W-2];
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            SCLK_LO: begin
                if (phase_end) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        rise = 1'b1;
                    end else begin
                        state_d   = GAP;
                        phase_d   = '0;
                        ss_n_d    = 1'b1;
                        done_d    = 1'b1;
                        rx_data_d = rx_sh_q;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_d = IDLE;
                    phase_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared sclk 0->1 action: miso is captured on the same edge sclk rises.
        if (rise) begin
            state_d   = SCLK_HI;
            sclk_d    = 1'b1;
            phase_d   = '0;
            rx_sh_d   = {rx_sh_q[FRAME_W-2:0], miso_s};
            bit_cnt_d = bit_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data   <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data   <= rx_data_d;
            sclk      <= sclk_d;
            mosi      <= mosi_d;
            ss_n      <= ss_n_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: frame-level reference model, slave model and protocol timing checks.
module tb_spi_master;

    localparam int CD  = 4;
    localparam int CD5 = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tx_data = '0;
    logic        busy, done, sclk, mosi, ss_n, miso;
    logic [31:0] rx_data;

    logic        start5 = 1'b0;
    logic [31:0] tx5 = '0;
    logic        busy5, done5, sclk5, mosi5, ss_n5;
    logic        miso5 = 1'b0;
    logic [31:0] rx5;

    logic        slave_loop = 1'b1;
    logic        slave_miso = 1'b0;
    logic [31:0] slave_word = '0;

    int checks   = 0;
    int failures = 0;

    assign miso = slave_loop ? mosi : slave_miso;

    spi_master #(.CLK_DIV(CD)) u_dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss_n    (ss_n),
        .miso    (miso)
    );

    spi_master #(.CLK_DIV(CD5)) u_dut5 (
        .clock   (clock),
        .reset   (reset),
        .start   (start5),
        .tx_data (tx5),
        .busy    (busy5),
        .done    (done5),
        .rx_data (rx5),
        .sclk    (sclk5),
        .mosi    (mosi5),
        .ss_n    (ss_n5),
        .miso    (miso5)
    );

    // Slave: presents word[31] when selected, then the next bit ~3 cycles after each sclk rise.
    logic ss_prev = 1'b1;
    logic sclk_prev_s = 1'b0;
    int   sl_cnt = 0;
    int   sl_idx = 0;
    always @(negedge clock) begin
        if (!ss_n && ss_prev) begin
            slave_miso = slave_word[31];
            sl_idx     = 30;
            sl_cnt     = 0;
        end else if (sclk && !sclk_prev_s) begin
            sl_cnt = 3;
        end else if (sl_cnt > 0) begin
            sl_cnt = sl_cnt - 1;
            if (sl_cnt == 0 && sl_idx >= 0) begin
                slave_miso = slave_word[sl_idx[4:0]];
                sl_idx     = sl_idx - 1;
            end
        end
        ss_prev     = ss_n;
        sclk_prev_s = sclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running exp finished");
        $fatal(1);
    end

    // Runs one frame on u_dut and measures it at frame level; protocol timing checked inline.
    task automatic do_frame(input logic [31:0] word, input bit spam,
                            output logic [31:0] mosi_word, output int rises,
                            output int ss_low, output int busy_cyc, output int dones);
        logic [31:0] rx_hold;
        logic        prev_sclk, prev_mosi, prev_ss_n;
        int          hi_run, lo_run, cyc;
        bit          after_fall;
        mosi_word = '0; rises = 0; ss_low = 0; busy_cyc = 0; dones = 0;
        hi_run = 0; lo_run = 0; cyc = 0; after_fall = 1'b0;
        @(negedge clock);
        start = 1'b1; tx_data = word;
        rx_hold = rx_data; prev_sclk = sclk; prev_mosi = mosi; prev_ss_n = ss_n;
        do begin
            @(negedge clock);
            cyc++;
            if (!ss_n) ss_low++;
            if (busy) busy_cyc++;
            if (done) begin
                dones++;
                rx_hold = rx_data;
            end else begin
                checks++;
                if (rx_data !== rx_hold) begin
                    failures++;
                    $display("FAIL rx_stable: got %h exp %h at cycle %0d", rx_data, rx_hold, cyc);
                end
            end
            if (sclk && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[30:0], mosi};
                if (after_fall) begin
                    checks++;
                    if (lo_run != CD) begin
                        failures++;
                        $display("FAIL sclk_low_len: got %0d exp %0d", lo_run, CD);
                    end
                end
                hi_run = 1;
            end else if (sclk) begin
                hi_run++;
                checks++;
                if (mosi !== prev_mosi || ss_n !== prev_ss_n) begin
                    failures++;
                    $display("FAIL stable_hi: got mosi=%b ss_n=%b exp mosi=%b ss_n=%b",
                             mosi, ss_n, prev_mosi, prev_ss_n);
                end
            end else if (prev_sclk) begin
                checks++;
                if (hi_run != CD) begin
                    failures++;
                    $display("FAIL sclk_high_len: got %0d exp %0d", hi_run, CD);
                end
                after_fall = 1'b1;
                lo_run = 1;
            end else begin
                lo_run++;
            end
            prev_sclk = sclk; prev_mosi = mosi; prev_ss_n = ss_n;
            start   = spam && (dones == 0);
            tx_data = $urandom;
        end while (busy && cyc < 2000);
        start = 1'b0;
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL frame_timeout: got busy=%b exp 0 after %0d cycles", busy, cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({ss_n, sclk, mosi, busy, done} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got ss_n,sclk,mosi,busy,done=%b exp 10000",
                     {ss_n, sclk, mosi, busy, done});
        end
        checks++;
        if (rx_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rx: got %h exp 00000000", rx_data);
        end
        checks++;
        if (ss_n5 !== 1'b1 || busy5 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut5: got ss_n=%b busy=%b exp 1 0", ss_n5, busy5);
        end
        start = 1'b1; tx_data = $urandom;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || ss_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_priority: got busy=%b ss_n=%b exp 0 1", busy, ss_n);
        end
        start = 1'b0; reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_frame();
        logic [31:0] mw;
        int r, sl, bc, dn;
        slave_loop = 1'b1;
        do_frame(32'hA5C3_0F01, 1'b0, mw, r, sl, bc, dn);
        checks++;
        if (r != 32) begin failures++; $display("FAIL single_pulses: got %0d exp 32", r); end
        checks++;
        if (mw !== 32'hA5C3_0F01) begin failures++; $display("FAIL single_mosi: got %h exp a5c30f01", mw); end
        checks++;
        if (rx_data !== 32'hA5C3_0F01) begin failures++; $display("FAIL single_rx: got %h exp a5c30f01", rx_data); end
        checks++;
        if (dn != 1) begin failures++; $display("FAIL single_done: got %0d exp 1", dn); end
        checks++;
        if (sl != 65 * CD) begin failures++; $display("FAIL single_ss_low: got %0d exp %0d", sl, 65 * CD); end
        checks++;
        if (bc != 66 * CD) begin failures++; $display("FAIL single_busy: got %0d exp %0d", bc, 66 * CD); end
    endtask

    task automatic test_slave_word();
        logic [31:0] mw, w;
        int r, sl, bc, dn;
        slave_loop = 1'b0; slave_word = 32'hDEAD_BEEF; w = $urandom;
        do_frame(w, 1'b0, mw, r, sl, bc, dn);
        checks++;
        if (rx_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL slave_rx: got %h exp deadbeef", rx_data); end
        checks++;
        if (mw !== w) begin failures++; $display("FAIL slave_mosi: got %h exp %h", mw, w); end
    endtask

    task automatic test_start_spam();
        logic [31:0] mw, w;
        int r, sl, bc, dn, extra;
        slave_loop = 1'b1; w = $urandom;
        do_frame(w, 1'b1, mw, r, sl, bc, dn);
        checks++;
        if (mw !== w) begin failures++; $display("FAIL spam_mosi: got %h exp %h", mw, w); end
        checks++;
        if (rx_data !== w) begin failures++; $display("FAIL spam_rx: got %h exp %h", rx_data, w); end
        checks++;
        if (dn != 1 || r != 32) begin failures++; $display("FAIL spam_frames: got done=%0d pulses=%0d exp 1 32", dn, r); end
        extra = 0;
        repeat (3 * CD) begin
            @(negedge clock);
            if (busy || !ss_n) extra++;
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL spam_queued: got %0d busy cycles exp 0", extra); end
    endtask

    task automatic test_random_frames();
        logic [31:0] mw, w, exp_rx;
        int r, sl, bc, dn;
        for (int i = 0; i < 4; i++) begin
            slave_loop = 1'($urandom_range(0, 1));
            slave_word = $urandom;
            w = $urandom;
            exp_rx = slave_loop ? w : slave_word;
            do_frame(w, 1'b0, mw, r, sl, bc, dn);
            checks++;
            if (rx_data !== exp_rx || mw !== w) begin
                failures++;
                $display("FAIL rand_frame%0d: got rx=%h mosi=%h exp rx=%h mosi=%h", i, rx_data, mw, exp_rx, w);
            end
            checks++;
            if (sl != 65 * CD || dn != 1) begin
                failures++;
                $display("FAIL rand_timing%0d: got ss_low=%0d done=%0d exp %0d 1", i, sl, dn, 65 * CD);
            end
        end
    endtask

    task automatic test_abort_reset();
        logic [31:0] mw;
        logic        prev_s;
        int r, sl, bc, dn, rises, cyc, bad;
        slave_loop = 1'b1;
        @(negedge clock);
        start = 1'b1; tx_data = 32'hFFFF_FFFF;
        rises = 0; cyc = 0; prev_s = sclk;
        do begin
            @(negedge clock);
            start = 1'b0; cyc++;
            if (sclk && !prev_s) rises++;
            prev_s = sclk;
        end while (rises < 10 && cyc < 500);
        checks++;
        if (rises != 10) begin failures++; $display("FAIL abort_reach: got %0d pulses exp 10", rises); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({ss_n, sclk, mosi, busy, done} !== 5'b10000 || rx_data !== 32'h0) begin
            failures++;
            $display("FAIL abort_state: got ss_n,sclk,mosi,busy,done=%b rx=%h exp 10000 0",
                     {ss_n, sclk, mosi, busy, done}, rx_data);
        end
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (done || busy) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL abort_done: got %0d active cycles exp 0", bad); end
        do_frame(32'h0000_0001, 1'b0, mw, r, sl, bc, dn);
        checks++;
        if (rx_data !== 32'h1 || mw !== 32'h1 || dn != 1) begin
            failures++;
            $display("FAIL abort_next: got rx=%h mosi=%h done=%0d exp 00000001 00000001 1", rx_data, mw, dn);
        end
    endtask

    task automatic test_back_to_back();
        logic prev_ss;
        int cyc, f1, r1, f2, cyc2;
        start5 = 1'b1; tx5 = $urandom;
        f1 = -1; r1 = -1; f2 = -1; cyc = 0; prev_ss = ss_n5;
        do begin
            @(negedge clock);
            cyc++;
            if (!ss_n5 && prev_ss) begin
                if (f1 < 0) f1 = cyc;
                else if (r1 >= 0 && f2 < 0) f2 = cyc;
            end
            if (ss_n5 && !prev_ss && r1 < 0 && f1 >= 0) r1 = cyc;
            prev_ss = ss_n5;
            tx5 = $urandom;
        end while (f2 < 0 && cyc < 3000);
        start5 = 1'b0;
        checks++;
        if (r1 - f1 != 65 * CD5) begin failures++; $display("FAIL b2b_ss_low: got %0d exp %0d", r1 - f1, 65 * CD5); end
        checks++;
        if (f2 < 0 || f2 - r1 != CD5 + 1) begin
            failures++;
            $display("FAIL b2b_gap: got %0d exp %0d", f2 - r1, CD5 + 1);
        end
        cyc2 = 0;
        while (busy5 && cyc2 < 1000) begin
            @(negedge clock);
            cyc2++;
        end
        checks++;
        if (busy5) begin failures++; $display("FAIL b2b_timeout: got busy=%b exp 0", busy5); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_slave_word();
        test_start_spam();
        test_random_frames();
        test_abort_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clocks per SCLK half-period; legal range 4..255.
REQ-002 SHALL have port clock  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  frame request, sampled only while busy=0.
REQ-005 SHALL have port tx_data  input  32  frame to transmit, MSB first.
REQ-006 SHALL have port busy  output  1  frame or inter-frame gap in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-008 SHALL have port rx_data  output  32  last received frame, MSB first.
REQ-009 SHALL have port sclk  output  1  SPI clock, idle low (mode 0).
REQ-010 SHALL have port mosi  output  1  serial data out.
REQ-011 SHALL have port ss_n  output  1  active-low slave select.
REQ-012 SHALL have port miso  input  1  serial data in, asynchronous to clock.

Function
REQ-013 SHALL register every output; no combinational input-to-output path.
REQ-014 SHALL implement states IDLE, SETUP, SCLK_HI, SCLK_LO, GAP.
REQ-015 SHALL, in IDLE with start=1 at edge T, capture tx_data and at T+1 drive ss_n=0, busy=1, mosi=tx_data[31], sclk=0, entering SETUP.
REQ-016 SHALL hold SETUP for CLK_DIV cycles, then raise sclk and enter SCLK_HI.
REQ-017 SHALL, on the edge where sclk goes 0->1, shift the current (optionally synchronised) miso into the rx shift register LSB.
REQ-018 SHALL hold SCLK_HI CLK_DIV cycles, then drive sclk=0 and, unless the bit was the 32nd, update mosi to the next lower bit on that same edge.
REQ-019 SHALL hold SCLK_LO CLK_DIV cycles; bit count <32 -> SCLK_HI, else ss_n=1, done=1, rx_data updated, enter GAP.
REQ-020 SHALL keep mosi and ss_n stable while sclk is high.
REQ-021 SHALL hold GAP CLK_DIV cycles with busy=1, then busy=0 and return to IDLE; start is accepted on the following edge.
REQ-022 SHALL keep ss_n low for exactly 65*CLK_DIV cycles per frame; busy high for 66*CLK_DIV cycles.
REQ-023 SHALL ignore start while busy=1 (no queuing); tx_data changes after capture have no effect.
REQ-024 SHALL keep rx_data unchanged except on the done cycle.
REQ-025 SHALL use a 6-bit bit counter and an 8-bit phase counter; counters do not wrap within a frame.

Reset
REQ-026 SHALL, on reset=1 at any edge including mid-frame, set state=IDLE, sclk=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=0, counters=0.
REQ-027 SHALL not pulse done for an aborted frame; reset has priority over start.

Configuration
REQ-028 SHALL, when SPI_MASTER_MISO_SYNC_EN is defined, pass miso through a 2-flop synchroniser before sampling (2-cycle extra delay; CLK_DIV>=4 still guarantees correct capture).
REQ-029 SHALL, when SPI_MASTER_MISO_SYNC_EN is undefined, sample raw miso directly; all other timing is identical.

Structure
REQ-030 SHALL place the state enum, FRAME_W=32 and CLK_DIV_MIN=4 in shared package spi_master_pkg.
REQ-031 SHALL implement the synchroniser as sub-module spi_sync2 (1-bit, 2 flops, reset to 0), instantiated only under SPI_MASTER_MISO_SYNC_EN.

Verification
REQ-032 Single frame: CLK_DIV=4, tx_data=32'hA5C3_0F01, miso tied to mosi -> 32 sclk pulses, rx_data=32'hA5C3_0F01, done one cycle, ss_n low 260 cycles.
REQ-033 Slave model returning 32'hDEADBEEF, MSB first, updating miso 3 cycles after each sclk rise -> rx_data=32'hDEADBEEF with and without the macro.
REQ-034 start pulsed every cycle during a frame with varying tx_data -> exactly one frame, mosi bits match first captured word only.
REQ-035 reset asserted after bit 10 -> next edge ss_n=1, sclk=0, busy=0, no done; subsequent frame 32'h0000_0001 completes correctly.
REQ-036 Back-to-back: start held high, CLK_DIV=5 -> second frame's ss_n fall occurs exactly CLK_DIV+1 cycles after first ss_n rise.
REQ-037 Protocol monitor over random frames -> mosi/ss_n never change while sclk=1; every sclk high/low phase exactly CLK_DIV cycles.
